// File: rtl/bus_bridge_req_arbiter_pkg.sv
// Shared types and constants for the bus bridge request arbiter:
// request/response payloads, arbiter state encoding and id helpers.
package bus_bridge_pkg;

  localparam int unsigned ARB_MAX_REQ = 8;
  localparam int unsigned ARB_ID_W    = 3;

  typedef struct packed {
    logic        is_write;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_bridge_req_t;

  typedef struct packed {
    logic       is_write;
    logic [7:0] read_data;
  } bus_bridge_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_RESP,
    ARB_RETURN
  } arb_state_t;

  // Requester index reached by stepping 'offset' places past 'last', wrapping at n.
  function automatic logic [ARB_ID_W-1:0] rr_next(input logic [ARB_ID_W-1:0] last,
                                                  input int unsigned offset,
                                                  input int unsigned n);
    return ARB_ID_W'((32'(last) + offset) % n);
  endfunction

endpackage

// File: rtl/bus_bridge_req_arbiter_if.sv
// Handshake/payload bundle between the upstream requesters, the arbiter and
// the downstream bridge master. 'slave' is the arbiter's view; 'master' is the
// view of the surrounding requesters and bridge.
interface bus_bridge_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import bus_bridge_pkg::*;

  logic             [NUM_REQ-1:0] up_req_valid;
  logic             [NUM_REQ-1:0] up_req_ready;
  bus_bridge_req_t  [NUM_REQ-1:0] up_req_payload;
  logic             [NUM_REQ-1:0] up_resp_valid;
  logic             [NUM_REQ-1:0] up_resp_ready;
  bus_bridge_resp_t               up_resp_payload;

  logic             dn_req_valid;
  logic             dn_req_ready;
  bus_bridge_req_t  dn_req_payload;
  logic             dn_resp_valid;
  logic             dn_resp_ready;
  bus_bridge_resp_t dn_resp_payload;

  modport master (
    output up_req_valid, up_req_payload, up_resp_ready,
    output dn_req_ready, dn_resp_valid, dn_resp_payload,
    input  up_req_ready, up_resp_valid, up_resp_payload,
    input  dn_req_valid, dn_req_payload, dn_resp_ready
  );

  modport slave (
    input  up_req_valid, up_req_payload, up_resp_ready,
    input  dn_req_ready, dn_resp_valid, dn_resp_payload,
    output up_req_ready, up_resp_valid, up_resp_payload,
    output dn_req_valid, dn_req_payload, dn_resp_ready
  );

endinterface

// File: rtl/bus_bridge_req_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit starting one place
// after the last grant, wrapping at NUM_REQ.
module bus_arb_rr_pick
  import bus_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ARB_ID_W-1:0] last_grant,
  output logic [ARB_ID_W-1:0] winner,
  output logic                valid
);

  // Widened to the id range so any 3-bit id can index it directly.
  logic [ARB_MAX_REQ-1:0] req_ext;
  logic [ARB_ID_W-1:0]    cand;

  // Scan NUM_REQ candidates in priority order; the first hit wins.
  always_comb begin
    req_ext = ARB_MAX_REQ'(req);
    valid   = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = rr_next(last_grant, i, NUM_REQ);
      if (!valid && req_ext[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/bus_bridge_req_arbiter.sv
// Round-robin request arbiter in front of a single-outstanding bus bridge.
// Accepts one upstream request, forwards it downstream, waits for the
// response and returns it to the owning requester before arbitrating again.
// Optional per-requester transaction counters: define BUS_ARB_STATS_EN.
module bus_bridge_req_arbiter
  import bus_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bus_bridge_req_arbiter_if.slave      bus,
  output logic                         busy,
  output logic [ARB_ID_W-1:0]          owner_id
`ifdef BUS_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0] txn_count
`endif
);

  arb_state_t             state, state_n;
  logic [ARB_ID_W-1:0]    owner;
  logic [ARB_ID_W-1:0]    last_grant;
  bus_bridge_req_t        req_lat;
  bus_bridge_resp_t       resp_lat;
  bus_bridge_req_t        sel_payload;
  logic [ARB_ID_W-1:0]    pick_winner;
  logic                   pick_valid;
  logic [ARB_MAX_REQ-1:0] resp_ready_ext;
  logic                   accept;
  logic                   resp_take;
  logic                   ret_hs;

  bus_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (bus.up_req_valid),
    .last_grant (last_grant),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // Payload of the current round-robin winner.
  always_comb begin
    sel_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ARB_ID_W'(i) == pick_winner) begin
        sel_payload = bus.up_req_payload[i];
      end
    end
  end

  // Next-state and handshake outputs, all derived from the registered state.
  always_comb begin
    state_n           = state;
    bus.up_req_ready  = '0;
    bus.up_resp_valid = '0;
    bus.dn_req_valid  = 1'b0;
    bus.dn_resp_ready = 1'b0;
    accept            = 1'b0;
    resp_take         = 1'b0;
    ret_hs            = 1'b0;
    resp_ready_ext    = ARB_MAX_REQ'(bus.up_resp_ready);
    case (state)
      ARB_IDLE: begin
        // Held off while in reset so no accept is visible during rst_n low.
        if (pick_valid && rst_n) begin
          bus.up_req_ready = NUM_REQ'(ARB_MAX_REQ'(1) << pick_winner);
          accept           = 1'b1;
          state_n          = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        bus.dn_req_valid = 1'b1;
        if (bus.dn_req_ready) begin
          state_n = ARB_WAIT_RESP;
        end
      end
      ARB_WAIT_RESP: begin
        bus.dn_resp_ready = 1'b1;
        if (bus.dn_resp_valid) begin
          resp_take = 1'b1;
          state_n   = ARB_RETURN;
        end
      end
      ARB_RETURN: begin
        bus.up_resp_valid = NUM_REQ'(ARB_MAX_REQ'(1) << owner);
        if (resp_ready_ext[owner]) begin
          ret_hs  = 1'b1;
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // State, ownership and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      last_grant <= ARB_ID_W'(NUM_REQ - 1);
      req_lat    <= '0;
      resp_lat   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        owner   <= pick_winner;
        req_lat <= sel_payload;
      end
      if (resp_take) begin
        resp_lat <= bus.dn_resp_payload;
      end
      if (ret_hs) begin
        last_grant <= owner;
      end
    end
  end

  assign bus.dn_req_payload  = req_lat;
  assign bus.up_resp_payload = resp_lat;
  assign busy                = (state != ARB_IDLE);
  assign owner_id            = owner;

`ifdef BUS_ARB_STATS_EN
  // Saturating count of completed transactions per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (ret_hs) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ARB_ID_W'(i) == owner && txn_count[i] != '1) begin
          txn_count[i] <= txn_count[i] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_bridge_req_arbiter.sv
// Self-checking bench for bus_bridge_req_arbiter: scenario tasks with a
// round-robin reference model computed from the grant rules.
module tb_bus_bridge_req_arbiter;
  import bus_bridge_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic [2:0] owner_id;
`ifdef BUS_ARB_STATS_EN
  logic [N-1:0][CW-1:0] txn_count;
`endif

  always #5 clk = ~clk;

  bus_bridge_req_arbiter_if #(.NUM_REQ(N)) bus ();

  bus_bridge_req_arbiter #(
    .NUM_REQ (N),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .owner_id (owner_id)
`ifdef BUS_ARB_STATS_EN
    ,
    .txn_count (txn_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int model_last;
  bus_bridge_req_t req_pl [N];

  // Reference: first requester in the rotated order last+1, last+2, ...
  function automatic int exp_winner(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int idx;
      idx = (last + k) % int'(N);
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bus_bridge_req_t rand_req();
    bus_bridge_req_t r;
    r.is_write = 1'($urandom);
    r.addr     = 16'($urandom);
    r.data     = 8'($urandom);
    return r;
  endfunction

  function automatic bus_bridge_resp_t rand_resp();
    bus_bridge_resp_t r;
    r.is_write  = 1'($urandom);
    r.read_data = 8'($urandom);
    return r;
  endfunction

  task automatic load_payloads();
    for (int i = 0; i < int'(N); i++) bus.up_req_payload[i] = req_pl[i];
  endtask

  task automatic idle_inputs();
    bus.up_req_valid    = '0;
    bus.up_resp_ready   = '0;
    bus.dn_req_ready    = 1'b0;
    bus.dn_resp_valid   = 1'b0;
    bus.dn_resp_payload = '0;
    load_payloads();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_last = int'(N) - 1;
  endtask

  // Drives one full transaction and reports what the DUT did; callers judge it.
  task automatic run_txn(input logic [N-1:0] vmask, input int dn_wait, input int resp_wait,
                         input int up_wait, input bus_bridge_resp_t rsp,
                         output int grant, output int lat, output bus_bridge_req_t exp_pl,
                         output bus_bridge_req_t dn_pl, output logic [N-1:0] resp_vec,
                         output bus_bridge_resp_t resp_pl, output int hold_bad,
                         output logic busy_end);
    int cnt;
    grant = -1; lat = -1; exp_pl = '0; dn_pl = '0; resp_vec = '0; resp_pl = '0;
    hold_bad = 0; busy_end = 1'b1;
    @(negedge clk);
    bus.up_req_valid = vmask;
    load_payloads();
    #1;
    if ($countones(bus.up_req_ready) == 1) begin
      for (int i = 0; i < int'(N); i++) if (bus.up_req_ready[i]) grant = i;
    end else if (bus.up_req_ready != '0) begin
      hold_bad++;
    end
    if (grant < 0) begin
      bus.up_req_valid = '0;
      return;
    end
    exp_pl = req_pl[grant];
    @(negedge clk);
    bus.up_req_valid = vmask & ~(N'(1) << grant);
    req_pl[grant] = rand_req();
    load_payloads();
    #1;
    cnt = 1;
    while (!bus.dn_req_valid && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    if (!bus.dn_req_valid) begin
      idle_inputs();
      return;
    end
    lat   = cnt;
    dn_pl = bus.dn_req_payload;
    for (int c = 0; c < dn_wait; c++) begin
      if (!bus.dn_req_valid || bus.dn_req_payload !== dn_pl || bus.up_req_ready != '0 || busy !== 1'b1)
        hold_bad++;
      @(negedge clk); #1;
    end
    bus.dn_req_ready = 1'b1;
    @(negedge clk);
    bus.dn_req_ready = 1'b0;
    #1;
    for (int c = 0; c < resp_wait; c++) begin
      bus.dn_resp_payload = rand_resp();
      if (bus.dn_resp_ready !== 1'b1 || bus.dn_req_valid !== 1'b0 || bus.up_resp_valid != '0 || busy !== 1'b1)
        hold_bad++;
      @(negedge clk); #1;
    end
    bus.dn_resp_valid   = 1'b1;
    bus.dn_resp_payload = rsp;
    @(negedge clk);
    bus.dn_resp_valid   = 1'b0;
    bus.dn_resp_payload = ~rsp;
    bus.up_resp_ready   = ~(N'(1) << grant);
    #1;
    resp_vec = bus.up_resp_valid;
    resp_pl  = bus.up_resp_payload;
    for (int c = 0; c < up_wait; c++) begin
      if (bus.up_resp_valid !== resp_vec || bus.up_resp_payload !== resp_pl ||
          bus.up_req_ready != '0 || busy !== 1'b1)
        hold_bad++;
      @(negedge clk); #1;
    end
    bus.up_resp_ready = N'(1) << grant;
    @(negedge clk);
    bus.up_resp_ready = '0;
    bus.up_req_valid  = '0;
    #1;
    busy_end = busy;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL reset_owner: got %0d expected 0", owner_id); end
    total++; if (bus.dn_req_valid !== 1'b0) begin bad++; $display("FAIL reset_dn_req_valid: got %0b expected 0", bus.dn_req_valid); end
    total++; if (bus.dn_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_dn_resp_ready: got %0b expected 0", bus.dn_resp_ready); end
    total++; if (bus.up_resp_valid !== '0) begin bad++; $display("FAIL reset_up_resp_valid: got %b expected 0", bus.up_resp_valid); end
    total++; if (bus.up_req_ready !== '0) begin bad++; $display("FAIL reset_up_req_ready: got %b expected 0", bus.up_req_ready); end
    total++; if (bus.dn_req_payload !== '0) begin bad++; $display("FAIL reset_dn_payload: got %h expected 0", bus.dn_req_payload); end
    total++; if (bus.up_resp_payload !== '0) begin bad++; $display("FAIL reset_up_payload: got %h expected 0", bus.up_resp_payload); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_rr_order();
    int g, l, hb; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv; bus_bridge_resp_t rp, rsp;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int t = 0; t < 5; t++) begin
      int ew;
      for (int i = 0; i < int'(N); i++) req_pl[i] = rand_req();
      rsp = rand_resp();
      ew = exp_winner(4'b1111, model_last);
      run_txn(4'b1111, 0, 0, 0, rsp, g, l, ep, dp, rv, rp, hb, be);
      total++; if (g != order[t]) begin bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", t, g, order[t]); end
      total++; if (rv !== (N'(1) << ew)) begin bad++; $display("FAIL rr_resp_vec[%0d]: got %b expected %b", t, rv, N'(1) << ew); end
      total++; if (rp !== rsp) begin bad++; $display("FAIL rr_resp_payload[%0d]: got %h expected %h", t, rp, rsp); end
      model_last = ew;
    end
  endtask

  task automatic test_single_write();
    int g, l, hb; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv; bus_bridge_resp_t rp, rsp;
    bus_bridge_req_t want;
    want.is_write = 1'b1; want.addr = 16'h1234; want.data = 8'hA5;
    req_pl[0] = want;
    rsp.is_write = 1'b1; rsp.read_data = 8'($urandom);
    run_txn(4'b0001, 0, 0, 0, rsp, g, l, ep, dp, rv, rp, hb, be);
    total++; if (g != 0) begin bad++; $display("FAIL write_grant: got %0d expected 0", g); end
    total++; if (l != 1) begin bad++; $display("FAIL write_latency: got %0d expected 1", l); end
    total++; if (dp !== want) begin bad++; $display("FAIL write_dn_payload: got %h expected %h", dp, want); end
    total++; if (rv !== 4'b0001) begin bad++; $display("FAIL write_resp_vec: got %b expected 0001", rv); end
    total++; if (rp.is_write !== 1'b1) begin bad++; $display("FAIL write_resp_is_write: got %0b expected 1", rp.is_write); end
    total++; if (be !== 1'b0) begin bad++; $display("FAIL write_busy_end: got %0b expected 0", be); end
    model_last = 0;
  endtask

  task automatic test_read_stall();
    int g, l, hb; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv; bus_bridge_resp_t rp, rsp;
    req_pl[2] = rand_req();
    req_pl[2].is_write = 1'b0;
    rsp.is_write = 1'b0; rsp.read_data = 8'h3C;
    run_txn(4'b0100, 5, 2, 0, rsp, g, l, ep, dp, rv, rp, hb, be);
    total++; if (g != 2) begin bad++; $display("FAIL read_grant: got %0d expected 2", g); end
    total++; if (dp !== ep) begin bad++; $display("FAIL read_dn_payload: got %h expected %h", dp, ep); end
    total++; if (hb != 0) begin bad++; $display("FAIL read_hold: got %0d violations expected 0", hb); end
    total++; if (rv !== 4'b0100) begin bad++; $display("FAIL read_resp_vec: got %b expected 0100", rv); end
    total++; if (rp.read_data !== 8'h3C) begin bad++; $display("FAIL read_data: got %h expected 3c", rp.read_data); end
    model_last = 2;
  endtask

  task automatic test_resp_hold();
    int g, l, hb, ew; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv; bus_bridge_resp_t rp, rsp;
    rsp = rand_resp();
    ew = exp_winner(4'b1111, model_last);
    run_txn(4'b1111, 1, 1, 10, rsp, g, l, ep, dp, rv, rp, hb, be);
    total++; if (g != ew) begin bad++; $display("FAIL hold_grant: got %0d expected %0d", g, ew); end
    total++; if (hb != 0) begin bad++; $display("FAIL hold_violations: got %0d expected 0", hb); end
    total++; if (rp !== rsp) begin bad++; $display("FAIL hold_resp_payload: got %h expected %h", rp, rsp); end
    total++; if (be !== 1'b0) begin bad++; $display("FAIL hold_busy_end: got %0b expected 0", be); end
    model_last = ew;
  endtask

  task automatic test_drop();
    int g, l, hb, ew; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv; bus_bridge_resp_t rp;
    ew = exp_winner(4'b0011, model_last);
    run_txn(4'b0011, 0, 0, 0, rand_resp(), g, l, ep, dp, rv, rp, hb, be);
    total++; if (g != ew) begin bad++; $display("FAIL drop_first_grant: got %0d expected %0d", g, ew); end
    model_last = ew;
    ew = exp_winner(4'b1000, model_last);
    run_txn(4'b1000, 0, 0, 0, rand_resp(), g, l, ep, dp, rv, rp, hb, be);
    total++; if (g != ew) begin bad++; $display("FAIL drop_second_grant: got %0d expected %0d", g, ew); end
    model_last = ew;
  endtask

  task automatic test_random();
    int g, l, hb, ew; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv, m; bus_bridge_resp_t rp, rsp;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < int'(N); i++) req_pl[i] = rand_req();
      m   = N'($urandom_range(1, 15));
      rsp = rand_resp();
      ew  = exp_winner(m, model_last);
      run_txn(m, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              rsp, g, l, ep, dp, rv, rp, hb, be);
      total++; if (g != ew) begin bad++; $display("FAIL rand_grant[%0d]: got %0d expected %0d mask %b", t, g, ew, m); end
      total++; if (l != 1) begin bad++; $display("FAIL rand_latency[%0d]: got %0d expected 1", t, l); end
      total++; if (dp !== ep) begin bad++; $display("FAIL rand_dn_payload[%0d]: got %h expected %h", t, dp, ep); end
      total++; if (rv !== (N'(1) << ew)) begin bad++; $display("FAIL rand_resp_vec[%0d]: got %b expected %b", t, rv, N'(1) << ew); end
      total++; if (rp !== rsp) begin bad++; $display("FAIL rand_resp_payload[%0d]: got %h expected %h", t, rp, rsp); end
      total++; if (hb != 0) begin bad++; $display("FAIL rand_hold[%0d]: got %0d violations expected 0", t, hb); end
      model_last = ew;
    end
  endtask

  task automatic test_reset_mid();
    int g, l, hb; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv; bus_bridge_resp_t rp;
    for (int i = 0; i < int'(N); i++) req_pl[i] = rand_req();
    @(negedge clk);
    bus.up_req_valid = 4'b0100;
    load_payloads();
    @(negedge clk);
    bus.up_req_valid = '0;
    bus.dn_req_ready = 1'b1;
    @(negedge clk);
    bus.dn_req_ready = 1'b0;
    #1;
    total++; if (bus.dn_resp_ready !== 1'b1) begin bad++; $display("FAIL mid_wait_state: got dn_resp_ready %0b expected 1", bus.dn_resp_ready); end
    rst_n = 1'b0;
    bus.up_req_valid  = '1;
    bus.up_resp_ready = '1;
    bus.dn_req_ready  = 1'b1;
    bus.dn_resp_valid = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
    total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL mid_rst_owner: got %0d expected 0", owner_id); end
    total++; if (bus.up_req_ready !== '0) begin bad++; $display("FAIL mid_rst_up_req_ready: got %b expected 0", bus.up_req_ready); end
    total++; if (bus.dn_resp_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_dn_resp_ready: got %0b expected 0", bus.dn_resp_ready); end
    total++; if (bus.dn_req_payload !== '0) begin bad++; $display("FAIL mid_rst_dn_payload: got %h expected 0", bus.dn_req_payload); end
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (bus.up_resp_valid !== '0 || bus.dn_req_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valids: got %b/%0b expected 0/0", bus.up_resp_valid, bus.dn_req_valid); end
    idle_inputs();
    rst_n = 1'b1;
    model_last = int'(N) - 1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.up_resp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL mid_abandon: got resp_valid %b busy %0b expected 0/0", bus.up_resp_valid, busy); end
    run_txn(4'b1111, 0, 0, 0, rand_resp(), g, l, ep, dp, rv, rp, hb, be);
    total++; if (g != 0) begin bad++; $display("FAIL mid_next_grant: got %0d expected 0", g); end
    model_last = 0;
  endtask

`ifdef BUS_ARB_STATS_EN
  task automatic test_stats();
    int g, l, hb; logic be; bus_bridge_req_t ep, dp; logic [N-1:0] rv; bus_bridge_resp_t rp;
    int done;
    apply_reset();
    #1;
    total++; if (txn_count !== '0) begin bad++; $display("FAIL stats_reset: got %h expected 0", txn_count); end
    done = 0;
    for (int t = 0; t < 17; t++) begin
      run_txn(4'b0010, 0, 0, 0, rand_resp(), g, l, ep, dp, rv, rp, hb, be);
      if (g == 1) done++;
      if (t == 0) begin
        total++; if (txn_count[1] !== CW'(1)) begin bad++; $display("FAIL stats_first: got %0d expected 1", txn_count[1]); end
      end
    end
    total++; if (txn_count[1] !== CW'((done > 15) ? 15 : done)) begin bad++; $display("FAIL stats_saturate: got %0d expected %0d", txn_count[1], (done > 15) ? 15 : done); end
    total++; if (txn_count[1] !== 4'hF) begin bad++; $display("FAIL stats_req1: got %h expected f", txn_count[1]); end
    total++; if (txn_count[0] !== '0 || txn_count[2] !== '0 || txn_count[3] !== '0) begin bad++; $display("FAIL stats_others: got %h expected only req1 counted", txn_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < int'(N); i++) req_pl[i] = '0;
    test_reset();
    test_rr_order();
    test_single_write();
    test_read_stall();
    test_resp_hold();
    test_drop();
    test_random();
    test_reset_mid();
`ifdef BUS_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/bus_bridge_req_arbiter.md
BUS_BRIDGE_REQ_ARBITER -- requirements
Module: bus_bridge_req_arbiter

Interface
REQ-001 Parameter NUM_REQ SHALL default to 4, meaning the number of upstream requesters (legal range 1..8).
REQ-002 Parameter CNT_W SHALL default to 16, meaning the width of each per-requester statistics counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 up_req_valid  input  NUM_REQ  SHALL carry the per-requester request valid.
REQ-006 up_req_ready  output  NUM_REQ  SHALL carry the per-requester request accept (one-hot or zero).
REQ-007 up_req_payload  input  NUM_REQ x bus_bridge_req_t  SHALL carry the per-requester request payload.
REQ-008 up_resp_valid  output  NUM_REQ  SHALL carry the per-requester response valid (one-hot or zero).
REQ-009 up_resp_ready  input  NUM_REQ  SHALL carry the per-requester response accept.
REQ-010 up_resp_payload  output  bus_bridge_resp_t  SHALL be the shared response payload, meaningful only to the requester whose up_resp_valid bit is set.
REQ-011 dn_req_valid / dn_req_ready / dn_req_payload  out / in / out  1 / 1 / bus_bridge_req_t  SHALL form the downstream request channel to the bridge master interface.
REQ-012 dn_resp_valid / dn_resp_ready / dn_resp_payload  in / out / in  1 / 1 / bus_bridge_resp_t  SHALL form the downstream response channel.
REQ-013 busy  output  1  SHALL be high whenever the state is not ARB_IDLE.
REQ-014 owner_id  output  3  SHALL hold the index of the current or most recent grant.

Function
REQ-015 The FSM SHALL have the states ARB_IDLE, ARB_ISSUE, ARB_WAIT_RESP and ARB_RETURN, and SHALL allow at most one transaction outstanding downstream.
REQ-016 ARB_IDLE: when any up_req_valid is set, the winner SHALL be the first set bit searched round-robin from (last_grant+1) mod NUM_REQ.
REQ-017 ARB_IDLE: up_req_ready[winner] SHALL assert combinationally in the same cycle; the handshake completes that cycle; the payload and owner are latched; next state is ARB_ISSUE.
REQ-018 ARB_ISSUE: dn_req_valid=1 with the latched payload, held stable until dn_req_ready; on handshake the next state is ARB_WAIT_RESP.
REQ-019 Latency: dn_req_valid SHALL first assert exactly 1 cycle after the upstream accept cycle.
REQ-020 ARB_WAIT_RESP: dn_resp_ready=1; on dn_resp_valid the response payload SHALL be latched and the next state is ARB_RETURN.
REQ-021 ARB_RETURN: up_resp_valid[owner]=1 with the latched response, held until up_resp_ready[owner]; on that handshake last_grant<=owner and the next state is ARB_IDLE.
REQ-022 No new upstream request SHALL be accepted in any state other than ARB_IDLE; up_req_ready SHALL be all-zero there.
REQ-023 up_resp_ready bits of non-owners SHALL be ignored; a requester dropping up_req_valid before grant SHALL simply lose eligibility.
REQ-024 Wrap: a search reaching index NUM_REQ-1 SHALL continue at 0; with NUM_REQ=1 requester 0 SHALL always win.
REQ-025 No combinational path SHALL exist from up_* inputs to dn_* outputs, nor from dn_* inputs to up_* outputs.

Reset
REQ-026 On rst_n low, irrespective of in-flight state: state=ARB_IDLE; all valid/ready outputs=0; busy=0; owner_id=0; latched payloads=0; last_grant=NUM_REQ-1 (so requester 0 wins first); counters=0.
REQ-027 A transaction interrupted by reset SHALL be abandoned with no response returned.

Configuration
REQ-028 Macro BUS_ARB_STATS_EN defined: output txn_count (NUM_REQ x CNT_W) SHALL be present; txn_count[owner] SHALL increment by 1 on each ARB_RETURN handshake and saturate at all-ones.
REQ-029 Macro BUS_ARB_STATS_EN undefined: txn_count and its counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 bus_bridge_pkg SHALL hold bus_bridge_req_t, bus_bridge_resp_t, the arb_state_t enum and the constant ARB_MAX_REQ=8.
REQ-031 A sub-module bus_arb_rr_pick (request vector plus last-grant pointer in; winner index and valid out; purely combinational) SHALL implement the round-robin search.

Verification
REQ-032 After reset, up_req_valid=4'b1111 -> grants in order 0,1,2,3,0 across successive transactions.
REQ-033 Single write, req0 addr 16'h1234 data 8'hA5 -> dn_req_valid 1 cycle after accept with identical payload; response is_write=1 returned on up_resp_valid[0] only.
REQ-034 Read by req2, dn_resp read_data=8'h3C after 5 cycles of dn_req_ready=0 -> payload held stable; up_resp_payload.read_data=8'h3C to requester 2.
REQ-035 up_resp_ready[owner] held low 10 cycles while other requesters are valid -> response held; no up_req_ready asserted; busy=1.
REQ-036 rst_n pulsed during ARB_WAIT_RESP -> all outputs 0 within the reset; the next grant goes to requester 0.
REQ-037 With BUS_ARB_STATS_EN, CNT_W=4, 17 transactions by req1 -> txn_count[1]=4'hF.
